// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer: frame geometry, widths and FSM encoding.
package fft_pkg;

  localparam int FFT_N_PAIRS = 128;
  localparam int FFT_IN_W    = 8;
  localparam int FFT_DATA_W  = 16;
  localparam int FFT_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LOAD,
    FLUSH,
    UNLOAD
  } state_t;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Bundles the control, sample-in, result-out and core-facing signals of the frame sequencer.
interface fft_frame_sequencer_if #(
  parameter int IN_W   = fft_pkg::FFT_IN_W,
  parameter int DATA_W = fft_pkg::FFT_DATA_W
);

  logic              start_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;

  logic              in_valid_i;
  logic              in_ready_o;
  logic [IN_W-1:0]   in_data_0_i;
  logic [IN_W-1:0]   in_data_1_i;

  logic              out_valid_o;
  logic              out_ready_i;
  logic [DATA_W-1:0] out_data_0_o;
  logic [DATA_W-1:0] out_data_1_o;
  logic              out_last_o;

  logic              fft_enable_o;
  logic              fft_reset_o;
  logic              fft_sync_o;
  logic [DATA_W-1:0] fft_data_0_o;
  logic [DATA_W-1:0] fft_data_1_o;
  logic              fft_sync_i;
  logic [DATA_W-1:0] fft_data_0_i;
  logic [DATA_W-1:0] fft_data_1_i;

  // Sequencer side.
  modport master (
    input  start_i, in_valid_i, in_data_0_i, in_data_1_i, out_ready_i,
           fft_sync_i, fft_data_0_i, fft_data_1_i,
    output busy_o, done_o, err_o, in_ready_o, out_valid_o, out_data_0_o, out_data_1_o,
           out_last_o, fft_enable_o, fft_reset_o, fft_sync_o, fft_data_0_o, fft_data_1_o
  );

  // Environment side: ADC source, result consumer and FFT core.
  modport slave (
    output start_i, in_valid_i, in_data_0_i, in_data_1_i, out_ready_i,
           fft_sync_i, fft_data_0_i, fft_data_1_i,
    input  busy_o, done_o, err_o, in_ready_o, out_valid_o, out_data_0_o, out_data_1_o,
           out_last_o, fft_enable_o, fft_reset_o, fft_sync_o, fft_data_0_o, fft_data_1_o
  );

endinterface

// File: rtl/fft_frame_sequencer.sv
// Frame controller for the cf_fft_256_8 core: loads one frame of sample pairs, flushes the
// pipeline with zeros and streams the result frame out under consumer backpressure.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int N_PAIRS = FFT_N_PAIRS,
  parameter int IN_W    = FFT_IN_W,
  parameter int DATA_W  = FFT_DATA_W,
  parameter int TIMEOUT = FFT_TIMEOUT
) (
  input logic                   clock_c,
  input logic                   reset_i,
  fft_frame_sequencer_if.master bus
);

  localparam int CNT_W = $clog2(N_PAIRS);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int PAD_W = DATA_W - IN_W;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(N_PAIRS - 1);
  localparam logic [TO_W-1:0]  LAST_TO   = TO_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] in_cnt;
  logic [CNT_W-1:0] out_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             done_q;
  logic             err_q;

  always_ff @(posedge clock_c) begin
    // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
    if (reset_i) begin
      state   <= IDLE;
      in_cnt  <= '0;
      out_cnt <= '0;
      to_cnt  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start_i) begin
            state <= CLEAR;
            err_q <= 1'b0;
          end
        end
        CLEAR: begin
          state   <= LOAD;
          in_cnt  <= '0;
          out_cnt <= '0;
          to_cnt  <= '0;
        end
        LOAD: begin
          if (bus.in_valid_i) begin
            if (in_cnt == LAST_BEAT) state <= FLUSH;
            else                     in_cnt <= in_cnt + 1'b1;
          end
        end
        FLUSH: begin
          // Enabled cycles only: a stalled consumer also freezes the timeout.
          if (bus.out_ready_i) begin
            if (bus.fft_sync_i) begin
              state   <= UNLOAD;
              out_cnt <= CNT_W'(1);
            end else if (to_cnt == LAST_TO) begin
              state <= IDLE;
              err_q <= 1'b1;
            end else begin
              to_cnt <= to_cnt + 1'b1;
            end
          end
        end
        UNLOAD: begin
          if (bus.out_ready_i) begin
            if (out_cnt == LAST_BEAT) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end else begin
              out_cnt <= out_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path through the case infers a latch.
    bus.in_ready_o   = 1'b0;
    bus.out_valid_o  = 1'b0;
    bus.out_last_o   = 1'b0;
    bus.fft_enable_o = 1'b0;
    bus.fft_reset_o  = 1'b0;
    bus.fft_sync_o   = 1'b0;
    bus.fft_data_0_o = '0;
    bus.fft_data_1_o = '0;
    unique case (state)
      IDLE: bus.fft_reset_o = 1'b1;
      CLEAR: begin
        bus.fft_reset_o  = 1'b1;
        bus.fft_enable_o = 1'b1;
      end
      LOAD: begin
        bus.in_ready_o   = 1'b1;
        bus.fft_enable_o = bus.in_valid_i;
        bus.fft_sync_o   = bus.in_valid_i && (in_cnt == '0);
        bus.fft_data_0_o = {bus.in_data_0_i, {PAD_W{1'b0}}};
        bus.fft_data_1_o = {bus.in_data_1_i, {PAD_W{1'b0}}};
      end
      FLUSH: begin
        bus.fft_enable_o = bus.out_ready_i;
        bus.out_valid_o  = bus.fft_sync_i;
      end
      UNLOAD: begin
        bus.fft_enable_o = bus.out_ready_i;
        bus.out_valid_o  = 1'b1;
        bus.out_last_o   = (out_cnt == LAST_BEAT);
      end
      default: ;
    endcase
  end

  assign bus.busy_o       = (state != IDLE);
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  // Core outputs hold while disabled, so the result pair stays stable under backpressure.
  assign bus.out_data_0_o = bus.fft_data_0_i;
  assign bus.out_data_1_o = bus.fft_data_1_i;

endmodule
